ufm_wb_ctrl: RTL and testbench
==============================

Name: ufm_wb_ctrl

Overview:
- Downstream execution stage for the event-save path.
- Accepts single page commands (cmd/ufm_page/GO) from the UFM read/write sequencer and runs the MachXO2 EFB configuration-port command frames over a Wishbone master to read, program or erase UFM.
- Moves the 16-byte page payload through port A of the shared 16x8 DPRAM.
- Reports BUSY/ERR back to the sequencer.

Parameters:
- EFB_BASE, 8'h70: Wishbone address of CFGCR; CFGTXDR=+1, CFGSR=+2, CFGRXDR=+3.
- POLL_LIMIT, 16'd50000: maximum status-poll frames per busy wait before timeout.
- ACK_TIMEOUT, 8'd255: maximum clocks waiting for wb_ack_i per access.

Ports:
- clk_i  in  1  system clock.
- resetn_i  in  1  synchronous active-low reset.
- cmd  in  3  1=READ page, 2=WRITE page, 3=ERASE UFM; all others illegal.
- ufm_page  in  11  UFM page address.
- GO  in  1  start request; sampled only while BUSY=0.
- BUSY  out  1  operation in progress.
- ERR  out  1  result of the last operation; level.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  8  Wishbone address.
- wb_dat_o  out  8  Wishbone write data.
- wb_dat_i  in  8  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- mem_we  out  1  DPRAM port A write enable.
- mem_ce  out  1  DPRAM port A chip enable.
- mem_addr  out  4  DPRAM port A address.
- mem_wr_data  out  8  DPRAM port A write data.
- mem_rd_data  in  8  DPRAM port A read data; 1-cycle latency after mem_ce.

Behaviour:
- Reset: every output is 0; FSM returns to IDLE on the next edge, including mid-frame. cyc/stb drop immediately; no close frame is issued.
- Acceptance: GO=1 in IDLE latches cmd/ufm_page; BUSY=1 from the next cycle; ERR cleared. GO while BUSY=1 is ignored.
- Illegal cmd: BUSY high exactly 1 cycle, ERR=1, no Wishbone traffic.
- Wishbone access: single beat. cyc=stb=1 held with stable adr/dat/we until wb_ack_i. Deassert for at least 1 cycle between accesses.
- Access timeout: no ack within ACK_TIMEOUT clocks sets ERR=1 and jumps to the CLOSE_ALL sequence.
- Frame structure: write 8'h80 to CFGCR, then N opcode/operand writes to CFGTXDR, then optional M reads from CFGRXDR, then write 8'h00 to CFGCR.
- Sequence for every legal cmd, in order:
  - ENABLE: 74 08 00 00, then POLL.
  - Command body (below).
  - DISABLE: 26 00 00.
  - BYPASS: FF FF FF FF.
  - BUSY falls after the BYPASS frame closes.
- Command bodies:
  - READ: SETADDR B4 00 00 00 40 00 {5'b0,page[10:8]} page[7:0]; then frame CA 10 00 01 + 16 RXDR reads. Byte k goes to mem_addr=k with mem_ce=mem_we=1 for one cycle, data=wb_dat_i captured on ack.
  - WRITE: SETADDR as above; then frame C9 00 00 01 + 16 TXDR writes, byte k read from mem_addr=k; then POLL. Assert mem_ce one cycle before the TXDR access; latch mem_rd_data the following cycle; mem_we=0.
  - ERASE: frame CB 00 00 00, then POLL.
- POLL: frame 3C 00 00 00 + 4 RXDR reads; status byte 2, bit4=busy, bit5=fail.
  - Repeat while busy=1.
  - fail=1 sets ERR.
  - More than POLL_LIMIT frames sets ERR.
  - In both error cases, continue to DISABLE/BYPASS.
- FSM states: IDLE, ACC (generic WB access, returns via sequence pointer), ENABLE, SETADDR, RDPAGE, WRPAGE, ERASE, POLL, DISABLE, BYPASS, DONE. A byte index (0..15) and frame-byte counter drive the sequence.
- Counters: byte index stops at 15, never wraps within a page; the poll counter saturates.
- DONE: BUSY=0, ERR holds until the next accepted GO.

Test Plan:
- READ page 11'h123 with a model returning RXDR bytes 8'hA0..8'hAF, busy=0 -> DPRAM[0..15]=A0..AF; SETADDR frame carries 01 23; BUSY high from 2nd cycle until BYPASS close; ERR=0.
- WRITE page 0 with DPRAM preloaded 00..0F and model busy for 3 polls -> TXDR sees C9 00 00 01 00..0F in order; 4 poll frames; ERR=0.
- ERASE with status fail bit set -> ERR=1; DISABLE and BYPASS frames still issued; BUSY=0.
- cmd=3'd5 with GO -> BUSY pulse of 1 cycle, ERR=1, wb_cyc_o never asserted.
- Model withholds wb_ack_i -> after ACK_TIMEOUT clocks ERR=1, BUSY falls after CLOSE_ALL; second GO during BUSY ignored.
- resetn_i low mid-RDPAGE (byte 7) -> next edge: all outputs 0, IDLE; following READ completes normally.

Source files
------------

// File: rtl/ufm_wb_ctrl_if.sv
// Wishbone master bus between ufm_wb_ctrl and the MachXO2 EFB.
// The controller takes the master modport and the EFB side takes the slave modport.
interface ufm_wb_ctrl_if;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/ufm_wb_ctrl.sv
// UFM page read/program/erase engine: issues EFB configuration-port frames over Wishbone
// and moves the 16-byte page payload through DPRAM port A.
module ufm_wb_ctrl #(
  parameter logic [7:0]  EFB_BASE    = 8'h70,
  parameter logic [15:0] POLL_LIMIT  = 16'd50000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [2:0]  cmd,
  input  logic [10:0] ufm_page,
  input  logic        GO,
  output logic        BUSY,
  output logic        ERR,
  ufm_wb_ctrl_if.master wb,
  output logic        mem_we,
  output logic        mem_ce,
  output logic [3:0]  mem_addr,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACC, S_ENABLE, S_SETADDR, S_RDPAGE, S_WRPAGE,
    S_ERASE, S_POLL, S_DISABLE, S_BYPASS, S_DONE
  } state_t;

  state_t      state_q, state_d, ret_q, ret_d, phase;
  logic [2:0]  cmd_q, cmd_d;
  logic [10:0] page_q, page_d;
  logic        err_q, err_d;
  logic [4:0]  fcnt_q, fcnt_d;
  logic [3:0]  bidx_q, bidx_d, bidx_inc;
  logic [15:0] pcnt_q, pcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  adr_q, adr_d, dat_q, dat_d, rx_q, rx_d, stat_q, stat_d;
  logic        we_q, we_d;
  logic        wr_mem_q, wr_mem_d;
  logic        fetch_q, fetch_d;
  logic        body_done_q, body_done_d;

  logic [4:0]  ntx, nrx, txidx, rxidx;
  logic        step_open, step_tx, step_rx, frame_end, wr_data_step, cmd_legal;

  function automatic logic [7:0] op_byte(input state_t ph, input logic [4:0] idx,
                                         input logic [10:0] pg);
    logic [7:0] b;
    b = 8'h00;
    case (ph)
      S_ENABLE:  if (idx == 5'd0) b = 8'h74; else if (idx == 5'd1) b = 8'h08;
      S_SETADDR: case (idx)
                   5'd0:    b = 8'hB4;
                   5'd4:    b = 8'h40;
                   5'd6:    b = {5'b0, pg[10:8]};
                   5'd7:    b = pg[7:0];
                   default: b = 8'h00;
                 endcase
      S_RDPAGE:  if (idx == 5'd0) b = 8'hCA; else if (idx == 5'd1) b = 8'h10;
                 else if (idx == 5'd3) b = 8'h01;
      S_WRPAGE:  if (idx == 5'd0) b = 8'hC9; else if (idx == 5'd3) b = 8'h01;
      S_ERASE:   if (idx == 5'd0) b = 8'hCB;
      S_POLL:    if (idx == 5'd0) b = 8'h3C;
      S_DISABLE: if (idx == 5'd0) b = 8'h26;
      S_BYPASS:  b = 8'hFF;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  // Frame geometry is taken from the issuing state, also while ACC is running its access.
  always_comb begin
    phase = (state_q == S_ACC) ? ret_q : state_q;
    ntx   = '0;
    nrx   = '0;
    case (phase)
      S_ENABLE:  ntx = 5'd4;
      S_SETADDR: ntx = 5'd8;
      S_RDPAGE:  begin ntx = 5'd4; nrx = 5'd16; end
      S_WRPAGE:  ntx = 5'd20;
      S_ERASE:   ntx = 5'd4;
      S_POLL:    begin ntx = 5'd4; nrx = 5'd4; end
      S_DISABLE: ntx = 5'd3;
      S_BYPASS:  ntx = 5'd4;
      default:   ntx = '0;
    endcase
    txidx        = fcnt_q - 5'd1;
    rxidx        = fcnt_q - ntx - 5'd1;
    step_open    = (fcnt_q == 5'd0);
    step_tx      = (fcnt_q >= 5'd1) && (fcnt_q <= ntx);
    step_rx      = (fcnt_q > ntx) && (fcnt_q <= ntx + nrx);
    frame_end    = (fcnt_q == ntx + nrx + 5'd2);
    wr_data_step = (phase == S_WRPAGE) && step_tx && (txidx >= 5'd4);
    cmd_legal    = (cmd_q == 3'd1) || (cmd_q == 3'd2) || (cmd_q == 3'd3);
    bidx_inc     = (bidx_q == 4'hF) ? bidx_q : bidx_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      cmd_q       <= '0;
      page_q      <= '0;
      err_q       <= 1'b0;
      fcnt_q      <= '0;
      bidx_q      <= '0;
      pcnt_q      <= '0;
      tcnt_q      <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      rx_q        <= '0;
      stat_q      <= '0;
      wr_mem_q    <= 1'b0;
      fetch_q     <= 1'b0;
      body_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cmd_q       <= cmd_d;
      page_q      <= page_d;
      err_q       <= err_d;
      fcnt_q      <= fcnt_d;
      bidx_q      <= bidx_d;
      pcnt_q      <= pcnt_d;
      tcnt_q      <= tcnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      rx_q        <= rx_d;
      stat_q      <= stat_d;
      wr_mem_q    <= wr_mem_d;
      fetch_q     <= fetch_d;
      body_done_q <= body_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cmd_d       = cmd_q;
    page_d      = page_q;
    err_d       = err_q;
    fcnt_d      = fcnt_q;
    bidx_d      = bidx_q;
    pcnt_d      = pcnt_q;
    tcnt_d      = tcnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    rx_d        = rx_q;
    stat_d      = stat_q;
    wr_mem_d    = 1'b0;
    fetch_d     = fetch_q;
    body_done_d = body_done_q;
    if (wr_mem_q) bidx_d = bidx_inc;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (GO) begin
          cmd_d       = cmd;
          page_d      = ufm_page;
          err_d       = 1'b0;
          bidx_d      = '0;
          fcnt_d      = '0;
          fetch_d     = 1'b0;
          body_done_d = 1'b0;
          state_d     = S_ENABLE;
        end
      end

      S_ACC: begin
        if (wb.wb_ack_i) begin
          fcnt_d  = fcnt_q + 5'd1;
          state_d = ret_q;
          if (!we_q && ret_q == S_RDPAGE) begin
            rx_d     = wb.wb_dat_i;
            wr_mem_d = 1'b1;
          end
          if (!we_q && ret_q == S_POLL && rxidx == 5'd2) stat_d = wb.wb_dat_i;
          if (wr_data_step) bidx_d = bidx_inc;
        end else if (tcnt_q >= ACK_TIMEOUT - 8'd1) begin
          // A dead bus during close-out would otherwise loop forever; give up there.
          err_d   = 1'b1;
          fcnt_d  = '0;
          fetch_d = 1'b0;
          state_d = (ret_q == S_DISABLE || ret_q == S_BYPASS) ? S_DONE : S_DISABLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      default: begin
        if (state_q == S_ENABLE && step_open && !cmd_legal) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (frame_end) begin
          fcnt_d = '0;
          case (state_q)
            S_ENABLE: begin state_d = S_POLL; pcnt_d = '0; end
            S_SETADDR: state_d = (cmd_q == 3'd1) ? S_RDPAGE : S_WRPAGE;
            S_RDPAGE:  state_d = S_DISABLE;
            S_WRPAGE, S_ERASE: begin
              body_done_d = 1'b1;
              pcnt_d      = '0;
              state_d     = S_POLL;
            end
            S_POLL: begin
              pcnt_d = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
              if (stat_q[5]) begin
                err_d   = 1'b1;
                state_d = S_DISABLE;
              end else if (stat_q[4]) begin
                if (pcnt_q >= POLL_LIMIT - 16'd1) begin
                  err_d   = 1'b1;
                  state_d = S_DISABLE;
                end else begin
                  state_d = S_POLL;
                end
              end else if (body_done_q) begin
                state_d = S_DISABLE;
              end else begin
                state_d = (cmd_q == 3'd3) ? S_ERASE : S_SETADDR;
              end
            end
            S_DISABLE: state_d = S_BYPASS;
            S_BYPASS:  state_d = S_DONE;
            default:   state_d = S_IDLE;
          endcase
        end else if (wr_data_step && !fetch_q) begin
          // DPRAM read launched this cycle; the byte is captured next cycle before ACC.
          fetch_d = 1'b1;
        end else begin
          fetch_d = 1'b0;
          tcnt_d  = '0;
          ret_d   = state_q;
          state_d = S_ACC;
          if (step_open) begin
            adr_d = EFB_BASE;
            we_d  = 1'b1;
            dat_d = 8'h80;
          end else if (step_tx) begin
            adr_d = EFB_BASE + 8'd1;
            we_d  = 1'b1;
            dat_d = wr_data_step ? mem_rd_data : op_byte(state_q, txidx, page_q);
          end else if (step_rx) begin
            adr_d = EFB_BASE + 8'd3;
            we_d  = 1'b0;
            dat_d = 8'h00;
          end else begin
            adr_d = EFB_BASE;
            we_d  = 1'b1;
            dat_d = 8'h00;
          end
        end
      end
    endcase
  end

  always_comb begin
    BUSY         = !(state_q == S_IDLE || state_q == S_DONE);
    ERR          = err_q;
    wb.wb_cyc_o  = (state_q == S_ACC);
    wb.wb_stb_o  = (state_q == S_ACC);
    wb.wb_we_o   = (state_q == S_ACC) && we_q;
    wb.wb_adr_o  = (state_q == S_ACC) ? adr_q : '0;
    wb.wb_dat_o  = (state_q == S_ACC) ? dat_q : '0;
    mem_ce       = wr_mem_q || (state_q == S_WRPAGE && wr_data_step && !fetch_q);
    mem_we       = wr_mem_q;
    mem_addr     = mem_ce ? bidx_q : '0;
    mem_wr_data  = wr_mem_q ? rx_q : '0;
  end

endmodule

// File: tb/tb_ufm_wb_ctrl.sv
// Directed bench for ufm_wb_ctrl with a behavioural EFB Wishbone slave and 16x8 DPRAM.
module tb_ufm_wb_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  cmd;
  logic [10:0] ufm_page;
  logic        GO;
  logic        BUSY, ERR;
  logic        mem_we, mem_ce;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wr_data, mem_rd_data;

  ufm_wb_ctrl_if wbi();

  ufm_wb_ctrl #(.EFB_BASE(8'h70), .POLL_LIMIT(16'd50000), .ACK_TIMEOUT(8'd255)) dut (
    .clk_i(clk), .resetn_i(resetn), .cmd(cmd), .ufm_page(ufm_page), .GO(GO),
    .BUSY(BUSY), .ERR(ERR), .wb(wbi),
    .mem_we(mem_we), .mem_ce(mem_ce), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model configuration (bench-driven)
  logic       model_clr = 1'b0;
  logic [7:0] cfg_rd_base = 8'h00;
  int         cfg_busy = 0;
  logic       cfg_fail = 1'b0;
  logic       cfg_ack = 1'b1;

  // model state
  logic [7:0] ops[$];
  logic [7:0] tx_log[$];
  int         txc, rxc, busy_left, body_polls, cr_close, acc_cnt, run, max_run, mem_wcnt;
  logic [7:0] cur_op, last_adr, last_dat, st;
  logic       after_body, last_we;
  logic       wb_ack = 1'b0;
  logic [7:0] wb_rdat = 8'h00;
  logic [7:0] dpram [16];
  logic [7:0] rd_q = 8'h00;

  assign wbi.wb_ack_i = wb_ack;
  assign wbi.wb_dat_i = wb_rdat;
  assign mem_rd_data  = rd_q;

  always @(posedge clk) begin
    if (model_clr) begin
      ops.delete(); tx_log.delete();
      txc = 0; rxc = 0; cur_op = 8'h00; after_body = 1'b0; busy_left = cfg_busy;
      body_polls = 0; cr_close = 0; acc_cnt = 0; run = 0; max_run = 0;
      last_adr = 8'h00; last_dat = 8'h00; last_we = 1'b0;
      wb_ack <= 1'b0;
    end else begin
      if (wbi.wb_cyc_o) begin
        if (run == 0) acc_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      wb_ack <= 1'b0;
      if (wbi.wb_cyc_o && wbi.wb_stb_o && !wb_ack && cfg_ack) begin
        wb_ack <= 1'b1;
        last_we = wbi.wb_we_o; last_adr = wbi.wb_adr_o; last_dat = wbi.wb_dat_o;
        if (wbi.wb_we_o) begin
          if (wbi.wb_adr_o == 8'h70 && wbi.wb_dat_o == 8'h80) begin txc = 0; rxc = 0; end
          if (wbi.wb_adr_o == 8'h70 && wbi.wb_dat_o == 8'h00) cr_close++;
          if (wbi.wb_adr_o == 8'h71) begin
            tx_log.push_back(wbi.wb_dat_o);
            if (txc == 0) begin
              ops.push_back(wbi.wb_dat_o);
              cur_op = wbi.wb_dat_o;
              if (cur_op == 8'hC9 || cur_op == 8'hCB) after_body = 1'b1;
              if (cur_op == 8'h3C && after_body) body_polls++;
            end
            txc++;
          end
        end else if (wbi.wb_adr_o == 8'h73) begin
          st = 8'h00;
          if (cur_op == 8'hCA) st = cfg_rd_base + 8'(rxc);
          else if (cur_op == 8'h3C && rxc == 2) begin
            if (after_body && busy_left > 0) begin st[4] = 1'b1; busy_left--; end
            if (after_body && cfg_fail) st[5] = 1'b1;
          end
          wb_rdat <= st;
          rxc++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (model_clr) begin
      for (int k = 0; k < 16; k++) dpram[k] <= 8'(k);
      mem_wcnt <= 0;
    end else if (mem_ce) begin
      if (mem_we) begin dpram[mem_addr] <= mem_wr_data; mem_wcnt <= mem_wcnt + 1; end
      rd_q <= dpram[mem_addr];
    end
  end

  task automatic model_reset();
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (BUSY !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    ok = (BUSY === 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd = '0; ufm_page = '0; GO = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({BUSY, ERR, wbi.wb_cyc_o, wbi.wb_stb_o, wbi.wb_we_o, wbi.wb_adr_o, wbi.wb_dat_o,
         mem_we, mem_ce, mem_addr, mem_wr_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: BUSY=%b ERR=%b cyc=%b, required all outputs 0", BUSY, ERR, wbi.wb_cyc_o);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [7:0] exp_ops [6] = '{8'h74, 8'h3C, 8'hB4, 8'hCA, 8'h26, 8'hFF};
    bit ok;
    cfg_rd_base = 8'hA0; cfg_busy = 0; cfg_fail = 1'b0; cfg_ack = 1'b1;
    model_reset();
    cmd = 3'd1; ufm_page = 11'h123; GO = 1'b1;
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL read_busy_cycle1: BUSY=%b required 0", BUSY); end
    @(negedge clk); GO = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL read_busy_cycle2: BUSY=%b required 1", BUSY); end
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_done: BUSY=%b required 0 within budget", BUSY); end
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL read_err: ERR=%b required 0", ERR); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (dpram[k] !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL read_dpram[%0d]: got %h required %h", k, dpram[k], 8'hA0 + 8'(k)); end
    end
    checks++;
    if (ops.size() != 6) begin errors++; $display("FAIL read_frame_count: got %0d required 6", ops.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (ops[i] !== exp_ops[i]) begin errors++; $display("FAIL read_opcode[%0d]: got %h required %h", i, ops[i], exp_ops[i]); end
    end
    checks++;
    if (tx_log.size() < 16 || tx_log[8] !== 8'hB4 || tx_log[12] !== 8'h40 || tx_log[14] !== 8'h01 || tx_log[15] !== 8'h23) begin
      errors++; $display("FAIL read_setaddr: got %h %h %h %h required B4 40 01 23", tx_log[8], tx_log[12], tx_log[14], tx_log[15]);
    end
    checks++;
    if (cr_close != 6 || last_we !== 1'b1 || last_adr !== 8'h70 || last_dat !== 8'h00) begin
      errors++; $display("FAIL read_close: closes=%0d last=%b/%h/%h required 6 1/70/00", cr_close, last_we, last_adr, last_dat);
    end
  endtask

  task automatic test_write();
    logic [7:0] exp_ops [10] = '{8'h74, 8'h3C, 8'hB4, 8'hC9, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h26, 8'hFF};
    logic [7:0] exp_hdr [4] = '{8'hC9, 8'h00, 8'h00, 8'h01};
    bit ok;
    cfg_busy = 3; cfg_fail = 1'b0; cfg_ack = 1'b1;
    model_reset();
    cmd = 3'd2; ufm_page = 11'h000; GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    wait_idle(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_done: BUSY=%b required 0 within budget", BUSY); end
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL write_err: ERR=%b required 0", ERR); end
    checks++;
    if (tx_log.size() < 36) begin errors++; $display("FAIL write_tx_len: got %0d required >=36", tx_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_log[16+i] !== exp_hdr[i]) begin errors++; $display("FAIL write_hdr[%0d]: got %h required %h", i, tx_log[16+i], exp_hdr[i]); end
      end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (tx_log[20+k] !== 8'(k)) begin errors++; $display("FAIL write_data[%0d]: got %h required %h", k, tx_log[20+k], 8'(k)); end
      end
    end
    checks++;
    if (body_polls != 4) begin errors++; $display("FAIL write_polls: got %0d required 4", body_polls); end
    checks++;
    if (ops.size() != 10) begin errors++; $display("FAIL write_frame_count: got %0d required 10", ops.size()); end
    else for (int i = 0; i < 10; i++) begin
      checks++;
      if (ops[i] !== exp_ops[i]) begin errors++; $display("FAIL write_opcode[%0d]: got %h required %h", i, ops[i], exp_ops[i]); end
    end
    checks++;
    if (mem_wcnt != 0) begin errors++; $display("FAIL write_mem_we: got %0d DPRAM writes required 0", mem_wcnt); end
  endtask

  task automatic test_erase_fail();
    logic [7:0] exp_ops [6] = '{8'h74, 8'h3C, 8'hCB, 8'h3C, 8'h26, 8'hFF};
    bit ok;
    cfg_busy = 0; cfg_fail = 1'b1; cfg_ack = 1'b1;
    model_reset();
    cmd = 3'd3; ufm_page = 11'h7FF; GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL erase_done: BUSY=%b required 0 within budget", BUSY); end
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL erase_err: ERR=%b required 1", ERR); end
    checks++;
    if (ops.size() != 6) begin errors++; $display("FAIL erase_frame_count: got %0d required 6", ops.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (ops[i] !== exp_ops[i]) begin errors++; $display("FAIL erase_opcode[%0d]: got %h required %h", i, ops[i], exp_ops[i]); end
    end
    cfg_fail = 1'b0;
  endtask

  task automatic test_illegal();
    cfg_ack = 1'b1;
    model_reset();
    cmd = 3'd5; GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL illegal_busy_on: BUSY=%b required 1", BUSY); end
    @(negedge clk);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL illegal_busy_off: BUSY=%b required 0", BUSY); end
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL illegal_err: ERR=%b required 1", ERR); end
    repeat (3) @(negedge clk);
    checks++;
    if (acc_cnt != 0) begin errors++; $display("FAIL illegal_no_wb: got %0d accesses required 0", acc_cnt); end
  endtask

  task automatic test_ack_timeout();
    bit ok;
    cfg_ack = 1'b0;
    model_reset();
    cmd = 3'd1; ufm_page = 11'h055; GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    repeat (20) @(negedge clk);
    cmd = 3'd2; GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done: BUSY=%b required 0 within budget", BUSY); end
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL timeout_err: ERR=%b required 1", ERR); end
    checks++;
    if (max_run != 255) begin errors++; $display("FAIL timeout_len: cyc held %0d clocks required 255", max_run); end
    checks++;
    if (acc_cnt != 2) begin errors++; $display("FAIL timeout_accesses: got %0d required 2", acc_cnt); end
    repeat (5) @(negedge clk);
    checks++;
    if (BUSY !== 1'b0 || acc_cnt != 2) begin errors++; $display("FAIL timeout_go_ignored: BUSY=%b accesses=%0d required 0/2", BUSY, acc_cnt); end
    cfg_ack = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int n;
    cfg_rd_base = 8'h30; cfg_busy = 0; cfg_fail = 1'b0; cfg_ack = 1'b1;
    model_reset();
    cmd = 3'd1; ufm_page = 11'h010; GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr === 4'd7) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (!(mem_we === 1'b1 && mem_addr === 4'd7)) begin errors++; $display("FAIL rst_mid_reach: byte 7 write not seen, mem_addr=%h", mem_addr); end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({BUSY, ERR, wbi.wb_cyc_o, wbi.wb_stb_o, wbi.wb_we_o, wbi.wb_adr_o, wbi.wb_dat_o,
         mem_we, mem_ce, mem_addr, mem_wr_data} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: BUSY=%b cyc=%b mem_we=%b, required all outputs 0", BUSY, wbi.wb_cyc_o, mem_we);
    end
    resetn = 1'b1;
    cfg_rd_base = 8'h50;
    model_reset();
    cmd = 3'd1; ufm_page = 11'h010; GO = 1'b1;
    @(negedge clk); GO = 1'b0;
    wait_idle(3000, ok);
    checks++;
    if (!ok || ERR !== 1'b0) begin errors++; $display("FAIL rst_mid_reread: done=%b ERR=%b required 1/0", ok, ERR); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (dpram[k] !== 8'h50 + 8'(k)) begin errors++; $display("FAIL rst_mid_dpram[%0d]: got %h required %h", k, dpram[k], 8'h50 + 8'(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_erase_fail();
    test_illegal();
    test_read();
    test_ack_timeout();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
